// File: rtl/ordered_arbiter_pkg.sv
// ordered_arbiter_pkg
// Shared definitions for the arrival-order arbiter slice:
//   - TIE_LSB / TIE_RR : tie-break selectors for simultaneous new requests
//   - log2()           : index width for a requester count, never below 1
// No ports; imported by arb_queue and ordered_arbiter.
package ordered_arbiter_pkg;

    localparam int TIE_LSB = 0;
    localparam int TIE_RR  = 1;

    // Smallest r >= 1 with 2**r >= n, so a two-requester arbiter still
    // gets a one-bit index.
    function automatic int log2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_queue.sv
// arb_queue
// Circular buffer of WIDTH entries, each an IW-bit requester index.
// Push and pop may happen in the same cycle; the count is then unchanged.
// The owner guarantees no push into a full queue unless a pop happens in
// the same cycle.
// Ports:
//   clock        in   clock, all updates on posedge
//   reset        in   synchronous active-high reset, empties the queue
//   push_i       in   append push_data_i at the tail this edge
//   push_data_i  in   IW-bit index to append
//   pop_i        in   drop the head entry this edge
//   head_o       out  index at the head, 0 while empty
//   count_o      out  number of stored entries, 0..WIDTH
//   empty_o      out  count_o == 0
module arb_queue
    import ordered_arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = log2(WIDTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  logic [IW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [IW-1:0] head_o,
    output logic [IW:0]   count_o,
    output logic          empty_o
);

    logic [IW-1:0] slots_q [WIDTH];
    logic [IW-1:0] headPtr_q, headPtr_d;
    logic [IW-1:0] tailPtr_q, tailPtr_d;
    logic [IW:0]   count_q, count_d;

    // Pointers wrap at WIDTH, which need not be a power of two.
    function automatic logic [IW-1:0] nextPtr(input logic [IW-1:0] p);
        return (int'(p) == WIDTH - 1) ? '0 : p + IW'(1);
    endfunction

    // Next-state pointers and occupancy; a simultaneous push and pop
    // leaves the count where it was.
    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (push_i) begin
            tailPtr_d = nextPtr(tailPtr_q);
        end
        if (pop_i) begin
            headPtr_d = nextPtr(headPtr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (IW+1)'(1);
            2'b01:   count_d = count_q - (IW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Register the pointers and write the tail slot. When full and pushing
    // while popping, tail equals head, so the head slot is reused only after
    // its value has been read this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
            if (push_i) begin
                slots_q[tailPtr_q] <= push_data_i;
            end
        end
    end

    assign empty_o = (count_q == '0);
    assign head_o  = empty_o ? '0 : slots_q[headPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ordered_arbiter.sv
// ordered_arbiter
// Grants requesters in the order their requests rose. At most one newly
// raised request is queued per cycle. Simultaneous arrivals are ordered
// either lowest index first or round-robin from one above the last queued
// index. With MAX_HOLD > 0, a holder granted for MAX_HOLD consecutive
// cycles is moved from the head to the tail of the queue.
// Ports:
//   clock         in   clock, all updates on posedge
//   reset         in   synchronous active-high reset, outputs forced to 0
//   requests      in   WIDTH level requests, held while using the resource
//   grant         out  IW-bit index at the queue head, 0 while empty
//   grant_valid   out  queue non-empty and the head is still requesting
//   grant_onehot  out  one-hot form of grant, 0 when grant_valid is low
//   queue_count   out  number of queued requesters, 0..WIDTH
module ordered_arbiter
    import ordered_arbiter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int TIE_MODE = TIE_LSB,
    parameter int MAX_HOLD = 0,
    parameter int IW       = log2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] requests,
    output logic [IW-1:0]    grant,
    output logic             grant_valid,
    output logic [WIDTH-1:0] grant_onehot,
    output logic [IW:0]      queue_count
);

    localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
    localparam logic [HCW-1:0] HOLD_MAX  = (MAX_HOLD > 0) ? HCW'(MAX_HOLD) : '0;

    logic [WIDTH-1:0] queued_q, queued_d;
    logic [IW-1:0]    rrPtr_q, rrPtr_d;
    logic [HCW-1:0]   holdCnt_q, holdCnt_d;

    logic [WIDTH-1:0] fresh;
    logic [WIDTH-1:0] rotated;
    logic             pickValid;
    logic [IW-1:0]    lsbIdx, rotEnc, rotIdx, freshIdx;
    int               srcIdx;

    logic [IW-1:0]    headIdx;
    logic [IW:0]      count;
    logic             empty;
    logic             headValid;
    logic             releasePop;
    logic             requeue;
    logic             freshPush;
    logic             pushEn, popEn;
    logic [IW-1:0]    pushData;

    arb_queue #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) uQueue (
        .clock       (clock),
        .reset       (reset),
        .push_i      (pushEn),
        .push_data_i (pushData),
        .pop_i       (popEn),
        .head_o      (headIdx),
        .count_o     (count),
        .empty_o     (empty)
    );

    assign fresh = requests & ~queued_q;

    // Pick one fresh requester. Round-robin rotates the fresh vector right
    // by rrPtr so an LSB search starts at rrPtr, then maps the result back.
    always_comb begin
        pickValid = |fresh;
        lsbIdx    = '0;
        rotEnc    = '0;
        rotated   = '0;
        srcIdx    = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (fresh[i]) begin
                lsbIdx = IW'(i);
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            srcIdx     = (i + int'(rrPtr_q)) % WIDTH;
            rotated[i] = fresh[srcIdx[IW-1:0]];
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                rotEnc = IW'(i);
            end
        end
        rotIdx   = IW'((int'(rotEnc) + int'(rrPtr_q)) % WIDTH);
        freshIdx = (TIE_MODE == TIE_RR) ? rotIdx : lsbIdx;
    end

    // Queue control. A requeue takes the push slot, so a fresh arrival in
    // the same cycle waits. A withdrawn entry is only removed once it
    // reaches the head, which is why releasePop looks only at the head.
    always_comb begin
        headValid  = ~empty & requests[headIdx];
        releasePop = ~empty & ~requests[headIdx];
        requeue    = (MAX_HOLD > 0) && headValid && (holdCnt_q == HOLD_LAST);
        freshPush  = pickValid & ~requeue;
        pushEn     = requeue | pickValid;
        pushData   = requeue ? headIdx : freshIdx;
        popEn      = releasePop | requeue;
    end

    // Membership, tie-break pointer and hold counter next state. A fresh
    // index is never queued, so it cannot collide with the popped head.
    always_comb begin
        queued_d  = queued_q;
        rrPtr_d   = rrPtr_q;
        holdCnt_d = holdCnt_q;
        if (freshPush) begin
            queued_d[freshIdx] = 1'b1;
            if (TIE_MODE == TIE_RR) begin
                rrPtr_d = IW'((int'(freshIdx) + 1) % WIDTH);
            end
        end
        if (releasePop) begin
            queued_d[headIdx] = 1'b0;
        end
        if (popEn) begin
            holdCnt_d = '0;
        end else if ((MAX_HOLD > 0) && headValid && (holdCnt_q != HOLD_MAX)) begin
            holdCnt_d = holdCnt_q + HCW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            queued_q  <= '0;
            rrPtr_q   <= '0;
            holdCnt_q <= '0;
        end else begin
            queued_q  <= queued_d;
            rrPtr_q   <= rrPtr_d;
            holdCnt_q <= holdCnt_d;
        end
    end

    // The queue clears only at the reset edge, so outputs are masked while
    // reset is high to read as idle during reset as well.
    always_comb begin
        grant        = reset ? '0 : headIdx;
        grant_valid  = ~reset & headValid;
        grant_onehot = grant_valid ? (WIDTH'(1) << grant) : '0;
        queue_count  = reset ? '0 : count;
    end

endmodule
